// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants, state codes and the stall priority encoder for the pipeline controller.
package pipeline_ctrl_pkg;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // Each stall vector holds the named stage and every stage upstream of it.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_ERET = 32'h0000000e;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ctrl_state_t;

    // The deepest requesting stage decides how much of the pipe is held.
    function automatic logic [5:0] stall_encode(input logic if_req,
                                                input logic id_req,
                                                input logic ex_req,
                                                input logic mem_req);
        logic [5:0] vec;
        if (mem_req)     vec = STALL_MEM;
        else if (ex_req) vec = STALL_EX;
        else if (id_req) vec = STALL_ID;
        else if (if_req) vec = STALL_IF;
        else             vec = STALL_NONE;
        return vec;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Stall-cycle performance counter plus a sticky watchdog on long stall runs.
module pipeline_ctrl_stall_watchdog #(
    parameter int MAX_STALL = 1024,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stalled,
    input  logic             clr_perf,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             stall_timeout
);

    localparam int RUN_W_MIN = $clog2(MAX_STALL + 1);
    localparam int RUN_W     = (RUN_W_MIN < 11) ? 11 : RUN_W_MIN;
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);

    logic [RUN_W-1:0] run_len;
    logic             run_hit;

    // The run reaches the limit on this edge (or is already parked there).
    assign run_hit = stalled && (run_len >= (RUN_LIMIT - 1'b1));

    // Consecutive-stall run length; parks at the limit so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_len <= '0;
        end else if (!stalled) begin
            run_len <= '0;
        end else if (run_len != RUN_LIMIT) begin
            run_len <= run_len + 1'b1;
        end
    end

    // Saturating stall-cycle counter; clear beats increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (clr_perf) begin
            stall_cycles <= '0;
        end else if (stalled && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    // Sticky timeout flag, cleared only by clr_perf or reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_timeout <= 1'b0;
        end else if (clr_perf) begin
            stall_timeout <= 1'b0;
        end else if (run_hit) begin
            stall_timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stall distribution, exception flush/redirect and stall monitoring.
//
// state | meaning
// RUN   | normal flow; stall driven from requests, exceptions may be taken
// FLUSH | one-cycle flush with redirect; requests and exceptions ignored
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_BASE  = 32'h00000020,
    parameter int          MAX_STALL = 1024,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_from_if,
    input  logic             stallreq_from_id,
    input  logic             stallreq_from_ex,
    input  logic             stallreq_from_mem,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    input  logic             clr_perf,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             stall_timeout
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    logic        take_exc;
    logic        stall_any;

    // State register and redirect target, loaded only when an exception is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            new_pc <= '0;
        end else begin
            state <= state_next;
            if (take_exc) begin
                new_pc <= (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_BASE;
            end
        end
    end

    // Next state and outputs; a MEM-stage wait defers any pending exception.
    always_comb begin
        state_next = state;
        take_exc   = 1'b0;
        stall      = STALL_NONE;
        flush      = 1'b0;
        case (state)
            RUN: begin
                if (rst) begin
                    stall = stall_encode(stallreq_from_if, stallreq_from_id,
                                         stallreq_from_ex, stallreq_from_mem);
                end
                if ((excepttype_i != 32'h0) && !stallreq_from_mem) begin
                    take_exc   = 1'b1;
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                flush      = 1'b1;
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign stall_any = (stall != STALL_NONE) ? STOP : NOSTOP;

    pipeline_ctrl_stall_watchdog #(
        .MAX_STALL(MAX_STALL),
        .CNT_W    (CNT_W)
    ) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .stalled      (stall_any),
        .clr_perf     (clr_perf),
        .stall_cycles (stall_cycles),
        .stall_timeout(stall_timeout)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_pipeline_ctrl;

    localparam logic [31:0] EXC_BASE  = 32'h00000020;
    localparam int          MAX_STALL = 4;
    localparam int          CNT_W     = 8;
    localparam int          CNT_MAX   = 255;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req = 1'b0, id_req = 1'b0, ex_req = 1'b0, mem_req = 1'b0;
    logic [31:0]       exc = '0;
    logic [31:0]       epc = '0;
    logic              clr = 1'b0;
    logic [5:0]        stall;
    logic              flush;
    logic [31:0]       new_pc;
    logic [CNT_W-1:0]  stall_cycles;
    logic              stall_timeout;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic        m_flush;
    logic [31:0] m_pc;
    int          m_cnt;
    int          m_run;
    logic        m_to;

    pipeline_ctrl #(
        .EXC_BASE (EXC_BASE),
        .MAX_STALL(MAX_STALL),
        .CNT_W    (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stallreq_from_if (if_req),
        .stallreq_from_id (id_req),
        .stallreq_from_ex (ex_req),
        .stallreq_from_mem(mem_req),
        .excepttype_i     (exc),
        .cp0_epc_i        (epc),
        .clr_perf         (clr),
        .stall            (stall),
        .flush            (flush),
        .new_pc           (new_pc),
        .stall_cycles     (stall_cycles),
        .stall_timeout    (stall_timeout)
    );

    always #5 clk = ~clk;

    // Number of held stages is (deepest requester + 1); vector is that many low ones.
    function automatic logic [5:0] exp_stall();
        int n;
        if (!rst || m_flush) return 6'h00;
        n = mem_req ? 5 : ex_req ? 4 : id_req ? 3 : if_req ? 2 : 0;
        return 6'((1 << n) - 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_flush = 1'b0;
        m_pc    = '0;
        m_cnt   = 0;
        m_run   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_update();
        logic [5:0] es;
        logic       busy;
        logic       take;
        es   = exp_stall();
        busy = (es != 6'h00);
        take = !m_flush && (exc != 32'h0) && !mem_req;
        if (clr) m_cnt = 0;
        else if (busy && m_cnt < CNT_MAX) m_cnt++;
        m_run = busy ? ((m_run < 100000) ? m_run + 1 : m_run) : 0;
        if (clr) m_to = 1'b0;
        else if (busy && m_run >= MAX_STALL) m_to = 1'b1;
        if (take) m_pc = (exc == 32'h0000000e) ? epc : EXC_BASE;
        m_flush = take;
    endtask

    task automatic compare_all();
        chk("stall",         32'(stall),         32'(exp_stall()));
        chk("flush",         32'(flush),         32'(m_flush));
        chk("new_pc",        new_pc,             m_pc);
        chk("stall_cycles",  32'(stall_cycles),  32'(m_cnt));
        chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
    endtask

    // One clock: compare on the falling edge, advance the model on the rising edge.
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        if (rst) model_update();
        #1;
    endtask

    task automatic set_req(input logic i, input logic d, input logic e, input logic m);
        if_req  = i;
        id_req  = d;
        ex_req  = e;
        mem_req = m;
    endtask

    function automatic logic [31:0] rand_exc();
        int pick;
        pick = int'($urandom_range(0, 9));
        if (pick <= 5) return 32'h0;
        if (pick == 6) return 32'h0000000e;
        if (pick == 7) return 32'h00000008;
        if (pick == 8) return 32'h0000000c;
        return $urandom;
    endfunction

    initial begin
        model_reset();
        // Reset with every request asserted
        rst = 1'b0;
        set_req(1, 1, 1, 1);
        exc = 32'h0000000c;
        #2;
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_flush", 32'(flush), 32'h0);
        chk("reset_new_pc", new_pc, 32'h0);
        step();
        step();
        exc = '0;
        rst = 1'b1;
        #1;
        chk("first_stall", 32'(stall), 32'h1f);
        step();

        // ID+EX, then EX drops, then ID drops
        set_req(0, 0, 0, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        set_req(0, 1, 1, 0);
        #1;
        chk("stall_id_ex", 32'(stall), 32'h0f);
        step();
        set_req(0, 1, 0, 0);
        #1;
        chk("stall_id", 32'(stall), 32'h07);
        step();
        set_req(0, 0, 0, 0);
        #1;
        chk("stall_none", 32'(stall), 32'h00);
        chk("stall_cycles_2", 32'(stall_cycles), 32'd2);
        step();

        // Ordinary exception, then a second one ignored during the flush cycle
        exc = 32'h0000000c;
        step();
        exc = 32'h00000008;
        #1;
        chk("exc_flush", 32'(flush), 32'h1);
        chk("exc_pc", new_pc, 32'h00000020);
        step();
        exc = '0;
        #1;
        chk("no_second_flush", 32'(flush), 32'h0);
        step();

        // eret redirects to EPC; target holds after the flush
        epc = 32'h80001234;
        exc = 32'h0000000e;
        step();
        exc = '0;
        epc = 32'h0;
        #1;
        chk("eret_flush", 32'(flush), 32'h1);
        chk("eret_pc", new_pc, 32'h80001234);
        step();
        chk("eret_pc_hold", new_pc, 32'h80001234);
        chk("eret_flush_drop", 32'(flush), 32'h0);

        // Exception deferred behind a MEM-stage wait
        exc = 32'h00000008;
        set_req(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("defer_stall", 32'(stall), 32'h1f);
            chk("defer_noflush", 32'(flush), 32'h0);
            step();
        end
        set_req(0, 0, 0, 0);
        #1;
        chk("defer_still_noflush", 32'(flush), 32'h0);
        step();
        exc = '0;
        #1;
        chk("defer_flush", 32'(flush), 32'h1);
        chk("defer_pc", new_pc, 32'h00000020);
        step();

        // Watchdog: IF held exactly MAX_STALL cycles
        clr = 1'b1;
        step();
        clr = 1'b0;
        set_req(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        chk("timeout_early", 32'(stall_timeout), 32'h0);
        step();
        set_req(0, 0, 0, 0);
        #1;
        chk("timeout_set", 32'(stall_timeout), 32'h1);
        step();
        step();
        chk("timeout_sticky", 32'(stall_timeout), 32'h1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("timeout_clr", 32'(stall_timeout), 32'h0);
        chk("cycles_clr", 32'(stall_cycles), 32'h0);

        // Counter saturation
        set_req(1, 0, 0, 0);
        for (int i = 0; i < 300; i++) step();
        chk("cycles_sat", 32'(stall_cycles), 32'd255);
        set_req(0, 0, 0, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;

        // Asynchronous reset in the middle of a flush cycle
        exc = 32'h0000000c;
        step();
        exc = '0;
        chk("pre_reset_flush", 32'(flush), 32'h1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_reset_flush", 32'(flush), 32'h0);
        chk("async_reset_pc", new_pc, 32'h0);
        step();
        rst = 1'b1;
        step();

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            set_req($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
            exc = rand_exc();
            epc = $urandom;
            clr = ($urandom_range(0, 30) == 0);
            if ($urandom_range(0, 200) == 0) begin
                rst = 1'b0;
                model_reset();
                step();
                rst = 1'b1;
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
